// File: rtl/exec_sequencer.sv
// Execute/writeback sequencer wrapped around a 16x16 register file: reads two
// operands, computes an ALU or shift-add MUL result, and writes it back once.
module exec_sequencer #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 4,
   parameter int MUL_ITERS = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       instr,
   input  logic              instrValid,
   output logic              instrReady,
   input  logic [DATA_W-1:0] outR0,
   input  logic [DATA_W-1:0] outR1,
   output logic [ADDR_W-1:0] rs,
   output logic [ADDR_W-1:0] rt,
   output logic [ADDR_W-1:0] rd1,
   output logic [DATA_W-1:0] writeData,
   output logic              regWrite,
   output logic              busy,
   output logic              done,
   output logic              zeroFlag
);

   localparam int CNT_W = $clog2(MUL_ITERS);
   localparam int SH_W  = $clog2(DATA_W);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_MUL, S_WB} state_t;

   state_t            state, state_nxt;
   logic [3:0]        op_q;
   logic [DATA_W-1:0] opa_p0, opb_p0;
   logic [DATA_W-1:0] acc, acc_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              mul_last;

   function automatic logic [DATA_W-1:0] alu(input logic [3:0] op,
                                             input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
      logic [DATA_W-1:0] r;
      case (op)
         4'd0:    r = a + b;
         4'd1:    r = a - b;
         4'd2:    r = a & b;
         4'd3:    r = a | b;
         4'd4:    r = a ^ b;
         4'd5:    r = a << b[SH_W-1:0];
         4'd6:    r = a >> b[SH_W-1:0];
         default: r = '0;
      endcase
      return r;
   endfunction

   assign mul_last   = (cnt == CNT_W'(MUL_ITERS - 1));
   assign acc_nxt    = opb_p0[cnt] ? (acc + (opa_p0 << cnt)) : acc;
   assign instrReady = (state == S_IDLE);
   assign busy       = (state != S_IDLE);
   // Combinational from state so an async reset in WB drops the strobe at once.
   assign regWrite   = (state == S_WB);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (instrValid) state_nxt = S_READ;
         S_READ:  state_nxt = S_EXEC;
         S_EXEC: begin
            if (op_q == 4'd7)  state_nxt = S_MUL;
            else if (op_q[3])  state_nxt = S_IDLE;
            else               state_nxt = S_WB;
         end
         S_MUL:   if (mul_last) state_nxt = S_WB;
         S_WB:    state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q      <= '0;
         rs        <= '0;
         rt        <= '0;
         rd1       <= '0;
         opa_p0    <= '0;
         opb_p0    <= '0;
         acc       <= '0;
         cnt       <= '0;
         writeData <= '0;
         done      <= 1'b0;
         zeroFlag  <= 1'b0;
      end else begin
         done <= (state == S_WB) || ((state == S_EXEC) && op_q[3]);
         case (state)
            S_IDLE: begin
               if (instrValid) begin
                  op_q <= instr[15:12];
                  rd1  <= instr[11:8];
                  rs   <= instr[7:4];
                  rt   <= instr[3:0];
               end
            end
            // operand capture stage
            S_READ: begin
               opa_p0 <= outR0;
               opb_p0 <= outR1;
            end
            S_EXEC: begin
               if (op_q < 4'd7) writeData <= alu(op_q, opa_p0, opb_p0);
               acc <= '0;
               cnt <= '0;
            end
            // shift-add multiply: fixed MUL_ITERS cycles whatever the operands
            S_MUL: begin
               acc <= acc_nxt;
               cnt <= cnt + 1'b1;
               if (mul_last) writeData <= acc_nxt;
            end
            S_WB:    zeroFlag <= (writeData == '0);
            default: ;
         endcase
      end
   end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
Multi-cycle execute/writeback controller that sits directly around the 16x16 register file. It accepts one instruction at a time and drives the file's read addresses. It captures the two read operands, computes an ALU result (shift-add for MUL), then issues a single-cycle write back into the file. It is both the producer of rs/rt/rd1/writeData/regWrite and the consumer of outR0/outR1.

Parameters:
DATA_W, 16, datapath and register width
ADDR_W, 4, register address width (16 registers)
MUL_ITERS, 16, shift-add iterations for MUL; must equal DATA_W

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
instr  input  16  instruction: [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt
instrValid  input  1  instruction present on instr
instrReady  output  1  high only in IDLE; transfer when instrValid&&instrReady
outR0  input  16  register file read data for rs
outR1  input  16  register file read data for rt
rs  output  4  read address A, to register file
rt  output  4  read address B, to register file
rd1  output  4  write address, to register file (select tied 0 externally)
writeData  output  16  write data, to register file
regWrite  output  1  one-cycle write strobe
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse in the cycle after WB or NOP completion
zeroFlag  output  1  registered; set when written result == 0

Behaviour:
- Reset (async, any state): state=IDLE; rs, rt, rd1, writeData = 0; regWrite, busy, done, zeroFlag = 0; instrReady = 1. An in-flight instruction is discarded with no write.
- States: IDLE, READ, EXEC, MUL, WB.
- IDLE: instrReady=1. On instrValid, latch op/rd/rs/rt into an instruction register; rs/rt outputs driven from the latch next cycle. Go to READ.
- READ (1 cycle): rs/rt stable. The file read is combinational; capture outR0->opA and outR1->opB at the end of the cycle. Go to EXEC.
- EXEC (1 cycle): compute result, modulo 2^16, with no carry/overflow output:
  - op 0 ADD: opA+opB
  - op 1 SUB: opA-opB
  - op 2 AND, op 3 OR, op 4 XOR
  - op 5 SLL: opA<<opB[3:0]
  - op 6 SRL: logical opA>>opB[3:0]
  - op 7 MUL: go to MUL instead of WB, with acc=0 and cnt=0.
  - ops 8-15 NOP: no write. Return to IDLE and pulse done the next cycle.
- MUL: each cycle, if opB[cnt] then acc += opA<<cnt (low 16 bits kept); cnt++. After MUL_ITERS cycles (cnt wraps 15->0), result=acc and go to WB. MUL total latency is fixed regardless of operand values.
- WB (1 cycle): regWrite=1, rd1=latched rd, writeData=result. The write commits on the rising edge ending WB. zeroFlag updates on the same edge. Next state IDLE, done=1 for that one cycle.
- Latency from accept edge to write commit: ALU ops 3 cycles; MUL 3+16=19 cycles. Back-to-back throughput: one ALU op per 4 cycles.
- Hazards: an instruction's operands are read after the previous write has committed, so no forwarding is needed. rd=rs or rd=rt is legal; the operands are already captured.
- instrValid outside IDLE is ignored (instrReady=0). instr must be held until accepted.
- rs/rt/rd1 hold their last latched values while IDLE. writeData holds its last result. regWrite is 0 everywhere except WB.
- Reset asserted during WB: the write must not commit. regWrite clears asynchronously.

Test Plan:
- Reset: assert reset mid-MUL -> regWrite=0 immediately, busy=0, instrReady=1; the target register is unchanged.
- ADD: preload R1=0x0005, R2=0x0003; instr=0x0312 -> R3=0x0008 written exactly 3 cycles after accept, done pulse, zeroFlag=0.
- Wrap/zero: R1=0xFFFF, R2=0x0001, ADD into R4 -> R4=0x0000, zeroFlag=1. SUB R2-R1 into R5 -> 0x0002.
- Shifts: R1=0x8001, R2=0x0004; SLL -> 0x0010, SRL -> 0x0800. R2=0x0013 shifts by 3 (opB[3:0]) -> SLL 0x0008.
- MUL: R1=0x0123, R2=0x0045 -> 0x4E6F after 19 cycles. 0xFFFF*0xFFFF -> 0x0001.
- Handshake/NOP/alias: instrValid held high while busy -> no second accept until IDLE. op 0xA -> no regWrite, done after 2 cycles. ADD R1,R1,R1 with R1=0x0007 -> R1=0x000E.
